qdrop: RTL and testbench

// - Complement of the take operation on 2-level queues: discards the first cfg.data
//   sub-transactions of each outer transaction and forwards the remainder unchanged.
// - Sits between a 2-level queue producer and consumer on dti links. Output is

---
 rtl/qdrop_pkg.sv | 33 +++
 rtl/qdrop_oreg.sv | 46 ++++
 rtl/qdrop.sv | 81 ++++++++
 tb/tb_qdrop.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qdrop_pkg.sv
// qdrop_pkg: shared definitions for the qdrop block.
//   EOT_SUB / EOT_ALL   end-of-transaction codes carried in the top two bits of a word
//   qdrop_mode_t        SKIP (still discarding leading sub-transactions) or PASS
//   QDROP_WORD_T(W)     packed {eot[1:0], data[W-1:0]} word layout
//   ends_sub/ends_outer helpers to decode an eot field
`ifndef QDROP_PKG_SV
`define QDROP_PKG_SV

// Width-parameterised word layout; a macro because a package typedef cannot
// depend on a module parameter.
`define QDROP_WORD_T(W) struct packed { logic [1:0] eot; logic [(W)-1:0] data; }

package qdrop_pkg;

    localparam logic [1:0] EOT_SUB = 2'b01;
    localparam logic [1:0] EOT_ALL = 2'b11;

    typedef enum logic {
        SKIP = 1'b0,
        PASS = 1'b1
    } qdrop_mode_t;

    function automatic logic ends_sub(input logic [1:0] eot);
        return (eot & EOT_SUB) == EOT_SUB;
    endfunction

    function automatic logic ends_outer(input logic [1:0] eot);
        return eot == EOT_ALL;
    endfunction

endpackage

`endif

// File: rtl/qdrop_oreg.sv
// qdrop_oreg: single-entry valid/ready output register.
//   clk, rst     clock, synchronous active-high reset
//   load         capture load_data this cycle
//   load_data    word to capture
//   drain        downstream ready
//   space        register can accept a load this cycle (empty or draining)
//   valid, data  registered output word
module qdrop_oreg #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         drain,
    output logic         space,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    // A load wins over a drain so a word leaving and a word arriving in the
    // same cycle keeps the register full.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
        end else if (drain) begin
            valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            data_reg <= load_data;
        end
    end

    assign space = !valid_reg || drain;
    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/qdrop.sv
// qdrop: drops the first cfg_data sub-transactions of every outer transaction of a
// 2-level queue and forwards the rest unchanged through a registered output.
//   clk, rst                          clock, synchronous active-high reset
//   cfg_valid, cfg_ready, cfg_data    drop count N; acknowledged with the outer terminator
//   din_valid, din_ready, din_data    input queue {eot[1:0], data}
//   dout_valid, dout_ready, dout_data output queue {eot[1:0], data}
module qdrop
    import qdrop_pkg::*;
#(
    parameter int W_DATA = 8,
    parameter int W_CFG  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [W_CFG-1:0]  cfg_data,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [W_DATA+1:0] din_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [W_DATA+1:0] dout_data
);

    typedef `QDROP_WORD_T(W_DATA) word_t;

    word_t             din_word;
    qdrop_mode_t       mode;
    logic [W_CFG-1:0]  cnt_reg;
    logic              drop;
    logic              terminator;
    logic              xfer;
    logic              load;
    logic              oreg_space;

    assign din_word = din_data;

    // A word is discarded only while still skipping and only if it is not an
    // outer terminator, so the consumer always sees the end of every outer
    // transaction. Discarded words never touch the output register, which is
    // why their acceptance ignores dout_ready.
    always_comb begin
        mode       = (cnt_reg != cfg_data) ? SKIP : PASS;
        terminator = ends_outer(din_word.eot);
        drop       = (mode == SKIP) && !din_word.eot[1];
        din_ready  = 1'b0;
        if (!rst && cfg_valid) begin
            din_ready = drop ? 1'b1 : oreg_space;
        end
        xfer      = din_valid && din_ready;
        load      = xfer && !drop;
        cfg_ready = xfer && terminator;
    end

    // Counts dropped sub-transactions; it only advances in SKIP so it stops at
    // cfg_data and cannot wrap. The terminator clears it for the next config.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (xfer && terminator) begin
            cnt_reg <= '0;
        end else if (xfer && drop && ends_sub(din_word.eot)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    qdrop_oreg #(
        .W(W_DATA + 2)
    ) u_oreg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (din_word),
        .drain     (dout_ready),
        .space     (oreg_space),
        .valid     (dout_valid),
        .data      (dout_data)
    );

endmodule

// File: tb/tb_qdrop.sv
// tb_qdrop: self-checking bench for qdrop. A reference model decides which input
// words survive the drop and queues them; a monitor pops and compares whenever the
// DUT hands a word downstream, and checks held data while downstream stalls.
module tb_qdrop;
    import qdrop_pkg::*;

    localparam int W_DATA = 8;
    localparam int W_CFG  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [W_CFG-1:0]  cfg_data;
    logic              din_valid;
    logic              din_ready;
    logic [W_DATA+1:0] din_data;
    logic              dout_valid;
    logic              dout_ready = 1'b1;
    logic [W_DATA+1:0] dout_data;

    logic [W_DATA+1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cfg_pulses = 0;
    int model_cnt = 0;
    int model_n = 0;
    int ready_mode = 0;

    always #5 clk = ~clk;

    qdrop #(
        .W_DATA(W_DATA),
        .W_CFG (W_CFG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data)
    );

    // Downstream ready pattern: 0 = always ready, 1 = toggle each cycle, 2 = stalled.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ~dout_ready;
            default: dout_ready = 1'b0;
        endcase
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Scoreboard consumer and stall-stability check.
    always @(negedge clk) begin
        if (!rst && dout_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_valid", 32'(dout_valid), 0);
            end else if (dout_ready) begin
                checkOutput("dout", 32'(dout_data), 32'(exp_q.pop_front()));
            end else begin
                checkOutput("stall_hold", 32'(dout_data), 32'(exp_q[0]));
            end
        end
        if (!rst && cfg_ready) begin
            cfg_pulses++;
        end
    end

    task automatic setCfg(input int n);
        cfg_data = W_CFG'(n);
        model_n  = n;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one word, predicting whether it survives; returns the stall cycles.
    task automatic applyStimulus(input logic [1:0] eot, input logic [7:0] data,
                                 output int waited);
        bit fwd;
        bit accepted;
        if (eot == EOT_ALL) begin
            fwd = 1'b1;
            model_cnt = 0;
        end else if (model_cnt < model_n) begin
            fwd = 1'b0;
            if (eot[0]) model_cnt++;
        end else begin
            fwd = 1'b1;
        end
        if (fwd) exp_q.push_back({eot, data});
        din_data  = {eot, data};
        din_valid = 1'b1;
        waited    = 0;
        accepted  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (din_ready) begin
                accepted = 1'b1;
                break;
            end
            waited++;
        end
        checkOutput("din_accept", 32'(accepted), 1);
        if (accepted) begin
            checkOutput("cfg_ack", 32'(cfg_ready), 32'(eot == EOT_ALL));
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
    endtask

    task automatic drainQueue();
        ready_mode = 0;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [9:0] t1[8];
    logic [9:0] t2[3];
    logic [9:0] t4[6];
    int waited;
    int pulses_before;

    initial begin
        t1 = '{{2'b00, 8'd1}, {2'b01, 8'd2}, {2'b00, 8'd3}, {2'b01, 8'd4},
               {2'b00, 8'd5}, {2'b01, 8'd6}, {2'b00, 8'd7}, {2'b11, 8'd8}};
        t2 = '{{2'b01, 8'd10}, {2'b01, 8'd11}, {2'b11, 8'd12}};
        t4 = '{{2'b00, 8'd1}, {2'b01, 8'd2}, {2'b00, 8'd3}, {2'b01, 8'd4},
               {2'b00, 8'd5}, {2'b11, 8'd6}};

        // Reset: outputs and readies held low.
        rst       = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = '0;
        din_valid = 1'b1;
        din_data  = {EOT_ALL, 8'h00};
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_dout_valid", 32'(dout_valid), 0);
        checkOutput("rst_din_ready", 32'(din_ready), 0);
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_valid", 32'(dout_valid), 0);
        checkOutput("post_rst_cnt", 32'(dut.cnt_reg), 0);

        // No input accepted without a config.
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        din_valid = 1'b1;
        din_data  = {EOT_SUB, 8'h77};
        @(negedge clk);
        checkOutput("no_cfg_ready", 32'(din_ready), 0);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        cfg_valid = 1'b1;

        $display("[TB] test 1: N=2, 4 subs x 2 words");
        setCfg(2);
        pulses_before = cfg_pulses;
        for (int i = 0; i < 8; i++) applyStimulus(t1[i][9:8], t1[i][7:0], waited);
        drainQueue();
        checkOutput("t1_cfg_pulses", cfg_pulses - pulses_before, 1);

        $display("[TB] test 2: N=0, pass-through latency");
        setCfg(0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(t2[i][9:8], t2[i][7:0], waited);
            @(negedge clk);
            checkOutput("lat_valid", 32'(dout_valid), 1);
            checkOutput("lat_data", 32'(dout_data), 32'(t2[i]));
            @(posedge clk);
            #1;
        end
        drainQueue();

        $display("[TB] test 3: N=5, early outer end");
        setCfg(5);
        applyStimulus(2'b00, 8'hA0, waited);
        applyStimulus(2'b01, 8'hB0, waited);
        applyStimulus(2'b00, 8'hC0, waited);
        applyStimulus(2'b11, 8'hD0, waited);
        @(negedge clk);
        checkOutput("t3_cnt_cleared", 32'(dut.cnt_reg), 0);
        @(posedge clk);
        #1;
        drainQueue();

        $display("[TB] test 4: N=1, toggling downstream ready");
        setCfg(1);
        ready_mode = 1;
        for (int i = 0; i < 6; i++) applyStimulus(t4[i][9:8], t4[i][7:0], waited);
        drainQueue();

        $display("[TB] test 5: back-to-back outer transactions");
        pulses_before = cfg_pulses;
        setCfg(1);
        applyStimulus(2'b01, 8'h20, waited);
        applyStimulus(2'b11, 8'h21, waited);
        setCfg(0);
        applyStimulus(2'b01, 8'h22, waited);
        applyStimulus(2'b11, 8'h23, waited);
        drainQueue();
        checkOutput("t5_cfg_pulses", cfg_pulses - pulses_before, 2);

        $display("[TB] test 6: reset with a pending output word");
        setCfg(1);
        ready_mode = 2;
        waitCycles(2);
        applyStimulus(2'b01, 8'h30, waited);
        checkOutput("drop_one_cycle", waited, 0);
        applyStimulus(2'b01, 8'h31, waited);
        @(negedge clk);
        checkOutput("held_valid", 32'(dout_valid), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        din_valid = 1'b1;
        din_data  = {EOT_ALL, 8'h3F};
        @(negedge clk);
        checkOutput("mid_rst_din_ready", 32'(din_ready), 0);
        checkOutput("mid_rst_cfg_ready", 32'(cfg_ready), 0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        din_valid  = 1'b0;
        ready_mode = 0;
        @(negedge clk);
        checkOutput("mid_rst_dout_valid", 32'(dout_valid), 0);
        @(posedge clk);
        #1;
        applyStimulus(2'b01, 8'h40, waited);
        applyStimulus(2'b11, 8'h41, waited);
        drainQueue();

        checkOutput("final_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
